// File: rtl/test_result_reporter.sv
// rtl/test_result_reporter.sv - tohost completion device with verdict latch and watchdog
//
// Purpose:
//   Watches the core's data-store port for the riscv-tests exit store to the tohost word.
//   The exit value decodes as follows:
//     1                 -> PASS
//     (testnum<<1) | 1  -> FAIL
//   A watchdog turns a hung run into a TIMEOUT verdict.
//   The verdict and the number of RUN cycles are held until the next start or reset.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   start         one-cycle pulse: clear verdict/counter and enter RUN
//   wr_valid      store request valid
//   wr_ready      store accepted this cycle (high only in RUN)
//   wr_addr       store byte address
//   wr_data       store data
//   wr_strb       store byte enables
//   done          a verdict is held
//   done_pulse    one-cycle strobe on entry to a verdict
//   pass          verdict is PASS
//   fail          verdict is FAIL
//   timeout       verdict is TIMEOUT
//   fail_testnum  tohost[31:1] captured on FAIL
//   cycle_count   RUN cycles, frozen at the verdict, saturating
module test_result_reporter #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  output logic             done,
  output logic             done_pulse,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      fail_testnum,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);
  // Last RUN cycle value before the watchdog fires; on that edge the counter
  // reaches TIMEOUT_CYCLES, so the frozen count equals the watchdog length.
  localparam logic [CNT_W-1:0] TO_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [30:0]      tn, tn_nxt;
  logic             pulse_q, pulse_nxt;
  logic             hit;

  assign wr_ready = (state == S_RUN);

  // Only full-word stores to the exact tohost address count; everything else
  // is accepted and dropped so the core never stalls on this device.
  assign hit = wr_valid && wr_ready && (wr_addr == TOHOST_ADDR) && (wr_strb == 4'hF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      tn      <= '0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tn      <= tn_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tn_nxt    = tn;
    pulse_nxt = 1'b0;
    if (start) begin
      // Start wins over any store in the same cycle; that store is lost.
      state_nxt = S_RUN;
      cnt_nxt   = '0;
      tn_nxt    = '0;
    end else if (state == S_RUN) begin
      if (cnt != CNT_MAX) begin
        cnt_nxt = cnt + 1'b1;
      end
      // Priority: verdict store beats the watchdog in the same cycle.
      if (hit && (wr_data == 32'd1)) begin
        state_nxt = S_PASS;
        pulse_nxt = 1'b1;
      end else if (hit && wr_data[0]) begin
        state_nxt = S_FAIL;
        tn_nxt    = wr_data[31:1];
        pulse_nxt = 1'b1;
      end else if (WD_EN && (cnt == TO_LAST)) begin
        state_nxt = S_TIMEOUT;
        pulse_nxt = 1'b1;
      end
    end
  end

  assign pass         = (state == S_PASS);
  assign fail         = (state == S_FAIL);
  assign timeout      = (state == S_TIMEOUT);
  assign done         = pass | fail | timeout;
  assign done_pulse   = pulse_q;
  assign fail_testnum = tn;
  assign cycle_count  = cnt;

endmodule
